// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run-mode controller producing a one-cycle CPU advance enable
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 slow_clk_in,
    input  logic                 btn_step,
    input  logic [1:0]           mode,
    input  logic                 step_clr,
    output logic                 cpu_en,
    output logic [CNT_WIDTH-1:0] step_count,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_PRESS_CHK = 3'b001,
        ST_FIRE      = 3'b010,
        ST_HELD      = 3'b011,
        ST_REL_CHK   = 3'b100
    } db_state_t;

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic      slow_s1, slow_s2, slow_s3;
    logic      rise, rise_q;
    logic      btn_s1, btn_s;
    db_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic      fire;
    logic      en_nxt;

    // rise is registered once so a slow-clock edge reaches cpu_en three edges after capture
    assign rise = slow_s2 & ~slow_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
            rise_q  <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            slow_s1 <= slow_clk_in;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
            rise_q  <= rise;
            btn_s1  <= btn_step;
            btn_s   <= btn_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (btn_s) begin
                    state_nxt = ST_PRESS_CHK;
                    cnt_nxt   = 16'd0;
                end
            end
            ST_PRESS_CHK: begin
                if (!btn_s)
                    state_nxt = ST_IDLE;
                else if (cnt == DB_LAST)
                    state_nxt = ST_FIRE;
                else
                    cnt_nxt = cnt + 16'd1;
            end
            ST_FIRE: state_nxt = ST_HELD;
            ST_HELD: begin
                if (!btn_s) begin
                    state_nxt = ST_REL_CHK;
                    cnt_nxt   = 16'd0;
                end
            end
            ST_REL_CHK: begin
                if (btn_s)
                    state_nxt = ST_HELD;
                else if (cnt == DB_LAST)
                    state_nxt = ST_IDLE;
                else
                    cnt_nxt = cnt + 16'd1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        fire      = (state == ST_FIRE);
        dbg_state = state;
    end

    // only the mode-selected source can assert cpu_en; fires in other modes are dropped
    always_comb begin
        en_nxt = 1'b0;
        case (mode)
            2'b00:   en_nxt = 1'b1;
            2'b01:   en_nxt = rise_q;
            2'b10:   en_nxt = fire;
            default: en_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            cpu_en <= en_nxt;
            if (step_clr)
                step_count <= '0;
            else if (cpu_en)
                step_count <= step_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

    localparam int DB = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          slow_clk_in = 1'b0;
    logic          btn_step = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          step_clr = 1'b0;
    logic          cpu_en;
    logic [CW-1:0] step_count;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .slow_clk_in (slow_clk_in),
        .btn_step    (btn_step),
        .mode        (mode),
        .step_clr    (step_clr),
        .cpu_en      (cpu_en),
        .step_count  (step_count),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cpu_en) pulses++;
        end
    endtask

    task automatic clear_count();
        step_clr = 1'b1;
        tick();
        step_clr = 1'b0;
    endtask

    logic [2:0] seq[$];
    logic [2:0] exp_seq [8] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    int np;
    int pos;

    initial begin
        // 1: reset state, then free run
        tick(); tick();
        check_eq("rst_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("rst_count", 32'(step_count), 32'd0);
        check_eq("rst_dbg", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq("free_cpu_en", 32'(cpu_en), 32'd1);
        end
        check_eq("free_count9", 32'(step_count), 32'd9);
        mode = 2'b11;
        tick();
        check_eq("halt_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("free_count10", 32'(step_count), 32'd10);

        // 2: slow auto-step, pulse 3 edges after capture
        clear_count();
        check_eq("clr_count", 32'(step_count), 32'd0);
        mode = 2'b01;
        for (int p = 0; p < 3; p++) begin
            slow_clk_in = 1'b1;
            np = 0;
            pos = -1;
            for (int i = 0; i < 20; i++) begin
                if (i == 10) slow_clk_in = 1'b0;
                tick();
                if (cpu_en) begin
                    np++;
                    pos = i;
                end
            end
            check_eq("slow_pulses", 32'(np), 32'd1);
            check_eq("slow_latency", 32'(pos), 32'd3);
        end
        check_eq("slow_count", 32'(step_count), 32'd3);

        // 3: bouncy press in manual mode
        clear_count();
        mode = 2'b10;
        seq.delete();
        seq.push_back(dbg_state);
        np = 0;
        btn_step = 1'b1; tick(); if (cpu_en) np++;
        if (dbg_state != seq[$]) seq.push_back(dbg_state);
        btn_step = 1'b0; tick(); if (cpu_en) np++;
        if (dbg_state != seq[$]) seq.push_back(dbg_state);
        btn_step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) btn_step = 1'b0;
            tick();
            if (cpu_en) np++;
            if (dbg_state != seq[$]) seq.push_back(dbg_state);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_en) np++;
            if (dbg_state != seq[$]) seq.push_back(dbg_state);
        end
        check_eq("bounce_pulses", 32'(np), 32'd1);
        check_eq("seq_len", 32'(seq.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < seq.size()) check_eq("seq_state", 32'(seq[i]), 32'(exp_seq[i]));
        check_eq("bounce_count", 32'(step_count), 32'd1);

        // 4: long hold gives one pulse; halt ignores presses
        btn_step = 1'b1;
        run_pulses(100, np);
        check_eq("hold_pulses", 32'(np), 32'd1);
        btn_step = 1'b0;
        run_pulses(12, np);
        check_eq("hold_rel_dbg", 32'(dbg_state), 32'd0);
        check_eq("hold_count", 32'(step_count), 32'd2);
        mode = 2'b11;
        btn_step = 1'b1;
        run_pulses(20, np);
        btn_step = 1'b0;
        run_pulses(12, pos);
        check_eq("halt_pulses", 32'(np + pos), 32'd0);
        check_eq("halt_count", 32'(step_count), 32'd2);

        // 5: counter wrap and clear priority
        clear_count();
        mode = 2'b00;
        for (int i = 0; i < 65535; i++) tick();
        check_eq("pre_wrap", 32'(step_count), 32'hFFFE);
        check_eq("pre_wrap_en", 32'(cpu_en), 32'd1);
        tick();
        check_eq("wrap_ffff", 32'(step_count), 32'hFFFF);
        mode = 2'b11;
        tick();
        check_eq("wrap_zero", 32'(step_count), 32'h0000);
        check_eq("wrap_en", 32'(cpu_en), 32'd0);
        tick();
        check_eq("wrap_hold", 32'(step_count), 32'h0000);
        mode = 2'b00;
        tick(); tick();
        check_eq("run_count1", 32'(step_count), 32'd1);
        step_clr = 1'b1;
        tick();
        step_clr = 1'b0;
        check_eq("clr_prio", 32'(step_count), 32'd0);
        check_eq("clr_prio_en", 32'(cpu_en), 32'd1);
        mode = 2'b11;
        tick();
        check_eq("post_clr", 32'(step_count), 32'd1);

        // 6: async reset mid-debounce
        mode = 2'b10;
        btn_step = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("mid_press_dbg", 32'(dbg_state), 32'd1);
        #2;
        rst = 1'b0;
        btn_step = 1'b0;
        #1;
        check_eq("async_cpu_en", 32'(cpu_en), 32'd0);
        check_eq("async_count", 32'(step_count), 32'd0);
        check_eq("async_dbg", 32'(dbg_state), 32'd0);
        tick();
        rst = 1'b1;
        run_pulses(10, np);
        check_eq("post_rst_pulses", 32'(np), 32'd0);
        check_eq("post_rst_dbg", 32'(dbg_state), 32'd0);
        btn_step = 1'b1;
        run_pulses(12, np);
        btn_step = 1'b0;
        run_pulses(10, pos);
        check_eq("fresh_pulses", 32'(np + pos), 32'd1);
        check_eq("fresh_count", 32'(step_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
